// File: rtl/exception_control.sv
// Exception entry sequencer for the multicycle MIPS datapath: captures EPC,
// fetches the handler vector byte from memory and loads it into the PC.
//
// state   | meaning
// IDLE    | waiting for an exception request
// CAPTURE | EPC strobe, vector address driven onto memory
// WAIT    | memory latency countdown, address held
// LOAD    | vector byte presented on pc_out with pc_load strobe
// DONE    | completion pulse, control unit released on next cycle
module exception_control #(
  parameter int MEM_LATENCY  = 2,
  parameter int VEC_OPCODE   = 253,
  parameter int VEC_OVERFLOW = 254,
  parameter int VEC_DIVZERO  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div_zero,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic        busy,
  output logic        epc_load,
  output logic [31:0] epc_out,
  output logic [31:0] mem_addr,
  output logic        mem_sel,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic [1:0]  exc_cause,
  output logic        exc_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        exc_any;
  logic [23:0] unused_data_hi;

  assign exc_any        = exc_opcode | exc_overflow | exc_div_zero;
  assign unused_data_hi = mem_data_in[31:8];

  // CAPTURE outputs are registered on the detection edge so they are visible
  // during the CAPTURE cycle itself; the PC is folded straight into EPC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      busy      <= 1'b0;
      epc_load  <= 1'b0;
      epc_out   <= 32'd0;
      mem_addr  <= 32'd0;
      mem_sel   <= 1'b0;
      pc_load   <= 1'b0;
      pc_out    <= 32'd0;
      exc_cause <= 2'b00;
      exc_done  <= 1'b0;
    end else begin
      epc_load <= 1'b0;
      pc_load  <= 1'b0;
      exc_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (exc_any) begin
            state    <= S_CAPTURE;
            busy     <= 1'b1;
            epc_load <= 1'b1;
            epc_out  <= pc_in - 32'd4;
            mem_sel  <= 1'b1;
            if (exc_opcode) begin
              exc_cause <= 2'b01;
              mem_addr  <= 32'(VEC_OPCODE);
            end else if (exc_overflow) begin
              exc_cause <= 2'b10;
              mem_addr  <= 32'(VEC_OVERFLOW);
            end else begin
              exc_cause <= 2'b11;
              mem_addr  <= 32'(VEC_DIVZERO);
            end
          end
        end
        S_CAPTURE: begin
          wait_cnt <= 4'(MEM_LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Last WAIT edge: Dataout is valid, register the vector for LOAD.
          if (wait_cnt == 4'd0) begin
            state   <= S_LOAD;
            pc_out  <= {24'b0, mem_data_in[7:0]};
            pc_load <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_LOAD: begin
          state    <= S_DONE;
          exc_done <= 1'b1;
          mem_sel  <= 1'b0;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_control.sv
// Bench for exception_control: two instances (memory latency 2 and 4) driven
// by shared exception/PC stimulus and checked against a cycle-offset model.
module tb_exception_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_overflow, exc_div_zero;
  logic [31:0] pc_in;

  logic        busy_w     [2];
  logic        epc_load_w [2];
  logic [31:0] epc_out_w  [2];
  logic [31:0] mem_addr_w [2];
  logic        mem_sel_w  [2];
  logic        pc_load_w  [2];
  logic [31:0] pc_out_w   [2];
  logic [1:0]  cause_w    [2];
  logic        done_w     [2];
  logic [31:0] mem_data_w [2];

  logic [31:0] mem [256];

  int vectors = 0;
  int miscompares = 0;
  int ecyc = 0;

  // Reference model: each sequence is described only by its start edge,
  // cause and captured values; outputs follow from the offset into it.
  int          lat    [2] = '{2, 4};
  bit          act    [2];
  int          s_cyc  [2];
  logic [1:0]  m_cause[2];
  logic [31:0] m_epc  [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_pc   [2];

  always #5 clk = ~clk;

  assign mem_data_w[0] = mem[mem_addr_w[0][7:0]];
  assign mem_data_w[1] = mem[mem_addr_w[1][7:0]];

  exception_control #(.MEM_LATENCY(2)) dut0 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div_zero(exc_div_zero),
    .pc_in(pc_in), .mem_data_in(mem_data_w[0]),
    .busy(busy_w[0]), .epc_load(epc_load_w[0]), .epc_out(epc_out_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_sel(mem_sel_w[0]), .pc_load(pc_load_w[0]),
    .pc_out(pc_out_w[0]), .exc_cause(cause_w[0]), .exc_done(done_w[0])
  );

  exception_control #(.MEM_LATENCY(4)) dut1 (
    .clk(clk), .reset(reset),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div_zero(exc_div_zero),
    .pc_in(pc_in), .mem_data_in(mem_data_w[1]),
    .busy(busy_w[1]), .epc_load(epc_load_w[1]), .epc_out(epc_out_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_sel(mem_sel_w[1]), .pc_load(pc_load_w[1]),
    .pc_out(pc_out_w[1]), .exc_cause(cause_w[1]), .exc_done(done_w[1])
  );

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d cycle %0d: got %h expected %h", tag, k, ecyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; s_cyc[k] = 0; m_cause[k] = 2'b00;
      m_epc[k] = 32'd0; m_addr[k] = 32'd0; m_pc[k] = 32'd0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int d;
      int L;
      logic e_busy, e_epc_ld, e_pc_ld, e_done, e_sel;
      L = lat[k];
      d = act[k] ? (ecyc - s_cyc[k] + 1) : 0;
      e_busy   = act[k] && d <= L + 3;
      e_epc_ld = act[k] && d == 1;
      e_pc_ld  = act[k] && d == L + 2;
      e_done   = act[k] && d == L + 3;
      e_sel    = act[k] && d <= L + 2;
      chk("busy",      k, 32'(busy_w[k]),     32'(e_busy));
      chk("epc_load",  k, 32'(epc_load_w[k]), 32'(e_epc_ld));
      chk("pc_load",   k, 32'(pc_load_w[k]),  32'(e_pc_ld));
      chk("exc_done",  k, 32'(done_w[k]),     32'(e_done));
      chk("mem_sel",   k, 32'(mem_sel_w[k]),  32'(e_sel));
      chk("exc_cause", k, 32'(cause_w[k]),    32'(m_cause[k]));
      chk("epc_out",   k, epc_out_w[k],       m_epc[k]);
      chk("pc_out",    k, pc_out_w[k],        m_pc[k]);
      if (e_sel || !act[k]) chk("mem_addr", k, mem_addr_w[k], m_addr[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ecyc++;
    if (reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit idle_pre;
        idle_pre = !act[k] || (ecyc - s_cyc[k] >= lat[k] + 4);
        if (idle_pre && (exc_opcode || exc_overflow || exc_div_zero)) begin
          act[k]   = 1'b1;
          s_cyc[k] = ecyc;
          m_epc[k] = pc_in - 32'd4;
          if (exc_opcode)        begin m_cause[k] = 2'b01; m_addr[k] = 32'd253; end
          else if (exc_overflow) begin m_cause[k] = 2'b10; m_addr[k] = 32'd254; end
          else                   begin m_cause[k] = 2'b11; m_addr[k] = 32'd255; end
        end else if (act[k] && (ecyc - s_cyc[k] + 1 == lat[k] + 2)) begin
          m_pc[k] = mem[m_addr[k][7:0]] & 32'h0000_00FF;
        end
      end
    end
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    reset = 1'b1;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div_zero = 1'b0;
    pc_in = 32'd0;
    model_clear();

    // Reset and idle
    steps(2);
    reset = 1'b0;
    steps(10);

    // Opcode exception
    mem[253] = 32'h1234_567C;
    pc_in = 32'h0000_0020;
    exc_opcode = 1'b1;
    step();
    exc_opcode = 1'b0;
    steps(12);
    chk("t2_epc", 0, epc_out_w[0], 32'h0000_001C);
    chk("t2_pc",  0, pc_out_w[0],  32'h0000_007C);

    // Priority, then held overflow starts a second sequence
    pc_in = 32'h0000_0100;
    exc_opcode = 1'b1; exc_overflow = 1'b1; exc_div_zero = 1'b1;
    step();
    chk("t3_cause", 0, 32'(cause_w[0]), 32'd1);
    chk("t3_addr",  0, mem_addr_w[0],   32'd253);
    exc_opcode = 1'b0; exc_div_zero = 1'b0;
    steps(6);
    chk("t3_cause2", 0, 32'(cause_w[0]), 32'd2);
    chk("t3_addr2",  0, mem_addr_w[0],   32'd254);
    steps(8);
    exc_overflow = 1'b0;
    steps(12);

    // EPC wrap with div-by-zero
    pc_in = 32'd0;
    exc_div_zero = 1'b1;
    step();
    exc_div_zero = 1'b0;
    steps(12);
    chk("t4_epc",  1, epc_out_w[1], 32'hFFFF_FFFC);
    chk("t4_addr", 1, 32'(cause_w[1]), 32'd3);

    // Vector byte masking
    mem[254] = 32'hDEAD_BE40;
    pc_in = $urandom;
    exc_overflow = 1'b1;
    step();
    exc_overflow = 1'b0;
    steps(12);
    chk("t5_pc", 0, pc_out_w[0], 32'h0000_0040);
    chk("t5_pc", 1, pc_out_w[1], 32'h0000_0040);

    // Reset during WAIT
    pc_in = 32'h0000_4444;
    exc_opcode = 1'b1;
    step();
    exc_opcode = 1'b0;
    steps(2);
    async_reset();
    steps(20);

    // Randomized traffic
    for (int a = 253; a < 256; a++) mem[a] = $urandom;
    for (int i = 0; i < 400; i++) begin
      exc_opcode   = ($urandom_range(0, 9) == 0);
      exc_overflow = ($urandom_range(0, 9) == 0);
      exc_div_zero = ($urandom_range(0, 9) == 0);
      pc_in = $urandom;
      if ($urandom_range(0, 79) == 0) async_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
